ascon_blk_sequencer: RTL and testbench
======================================

// Module: ascon_blk_sequencer
// PURPOSE
//  Top-level AEAD sequencer for the Ascon-128 encrypt datapath. Walks the initialization, AD, PT and
//  finalization phases. Drives the block counters into the padding unit and start/round commands to
//  the permutation core. Issues per-block absorb/CT-write strobes and a tag handshake.
// PARAMETERS
//  DATA_AW   7            byte-address width of AD/PT buffers
//  BLOCK_AW  DATA_AW-3    64-bit block index width
//  ROUNDS_A  12           permutation rounds for init/final (p^a)
//  ROUNDS_B  6            permutation rounds for AD/PT blocks (p^b)
// PORTS
//  clk_i          in   1           clock
//  rst_ni         in   1           async reset, active low
//  start_i        in   1           start one encryption (ignored while busy_o=1)
//  ad_empty_i     in   1           AD length is 0; skip AD phase
//  ad_blk_no_i    in   BLOCK_AW    index of last (padded) AD block, from padding unit
//  pt_blk_no_i    in   BLOCK_AW+1  index of last (padded) PT block, from padding unit
//  ad_blk_cnt_o   out  BLOCK_AW    current AD block index to padding unit
//  pt_blk_cnt_o   out  BLOCK_AW+1  current PT block index to padding unit
//  perm_start_o   out  1           1-cycle pulse: start permutation
//  perm_rounds_o  out  4           round count, valid with perm_start_o
//  perm_done_i    in   1           1-cycle pulse: permutation finished
//  init_o         out  1           1-cycle: load IV||K||N into state
//  key_xor_o      out  1           1-cycle: XOR key into state (post-init / pre-final)
//  absorb_ad_o    out  1           1-cycle: XOR padded AD block into rate
//  dom_sep_o      out  1           1-cycle: XOR domain-separation bit
//  ct_valid_o     out  1           CT block valid (rate XOR padded PT)
//  ct_ready_i     in   1           CT sink ready
//  absorb_pt_o    out  1           = ct_valid_o & ct_ready_i; commit CT into rate
//  tag_valid_o    out  1           tag valid
//  tag_ready_i    in   1           tag sink ready
//  busy_o         out  1           high from accepted start until tag handshake
//  done_o         out  1           1-cycle pulse after tag handshake
// BEHAVIOUR
//  - Reset: FSM=IDLE; counters=0; all outputs 0. Async reset mid-op aborts immediately; no done_o.
//  - start_i in IDLE: latch ad_empty_i, ad_blk_no_i, pt_blk_no_i (held for the whole op); clear counters;
//    pulse init_o; go INIT.
//  - INIT: perm_start_o, rounds=ROUNDS_A, go W_INIT. W_INIT: on perm_done_i pulse key_xor_o.
//    Then go DOMSEP if latched ad_empty, else AD.
//  - AD: absorb_ad_o with ad_blk_cnt_o; next cycle perm_start_o(ROUNDS_B), go W_AD.
//    W_AD: on perm_done_i go DOMSEP if cnt==latched ad_blk_no, else cnt+1 and go AD.
//  - DOMSEP: dom_sep_o for 1 cycle, go PT.
//  - PT: ct_valid_o held until ct_ready_i; ct_valid_o must not drop without a handshake.
//    On handshake go FINAL if cnt==latched pt_blk_no. Otherwise perm_start_o(ROUNDS_B), go W_PT.
//    W_PT: on perm_done_i do cnt+1, go PT.
//  - FINAL: key_xor_o, next cycle perm_start_o(ROUNDS_A), go W_FIN. W_FIN: on perm_done_i pulse
//    key_xor_o, go TAG.
//  - TAG: tag_valid_o until tag_ready_i; on handshake pulse done_o, busy_o=0, go IDLE.
//  - perm_done_i outside a W_* state, or in the same cycle as perm_start_o: ignored.
//  - Counters never wrap. Max AD index 2^BLOCK_AW-1; max PT index 2^(BLOCK_AW+1)-1.
//    Last-block compare is exact equality on latched values.
//  - Latency (zero-wait permutation done 1 cycle after start, sinks always ready):
//    one AD block costs 3 cycles. A non-final PT block costs 3 cycles.
//  - At most one of init_o/key_xor_o/absorb_ad_o/dom_sep_o/absorb_pt_o is high in any cycle.
// TESTING
//  - ad_empty=1, pt_blk_no=0, perm done 1 cycle after start -> pulse order: init, permA, key_xor,
//    dom_sep, 1 CT (cnt=0), key_xor, permA, key_xor, tag, done. No absorb_ad_o.
//  - ad_blk_no=2, pt_blk_no=3 -> absorb_ad_o at cnt 0,1,2 with 3 permB between.
//    4 CT handshakes at cnt 0..3, 3 permB between them, no permB after cnt 3.
//  - ct_ready_i low 5 cycles on PT block 1 -> ct_valid_o stays high, cnt stays 1,
//    absorb_pt_o only on the ready cycle.
//  - start_i pulsed during W_AD, ad_blk_no_i changed mid-op -> ignored; sequence unchanged.
//  - rst_ni low during W_PT -> all outputs 0 asynchronously. After release, start_i runs a clean op from cnt 0.
//  - Spurious perm_done_i in IDLE/PT/TAG and in a perm_start_o cycle -> no state change.

Source files
------------

// File: rtl/ascon_blk_sequencer.sv
// ----------------------------------------------------------------------------
// ascon_blk_sequencer
//
// Control sequencer for the Ascon-128 encrypt datapath. It steps through
// initialization, associated-data absorption, plaintext encryption and
// finalization. It drives the block counters into the padding unit and issues
// start/round commands to the permutation core. It also produces the per-block
// strobes for the state datapath and the CT/tag handshakes.
//
// Ports
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   start_i          begin one encryption (ignored while busy_o is high)
//   ad_empty_i       associated data is empty; the AD phase is skipped
//   ad_blk_no_i      index of the last padded AD block (latched at start)
//   pt_blk_no_i      index of the last padded PT block (latched at start)
//   ad_blk_cnt_o     current AD block index to the padding unit
//   pt_blk_cnt_o     current PT block index to the padding unit
//   perm_start_o     one-cycle permutation start
//   perm_rounds_o    round count, valid with perm_start_o
//   perm_done_i      one-cycle permutation completion
//   init_o           load IV||K||N into the state
//   key_xor_o        XOR the key into the state (after init / around final)
//   absorb_ad_o      XOR the padded AD block into the rate
//   dom_sep_o        XOR the domain-separation bit
//   ct_valid_o       ciphertext block valid
//   ct_ready_i       ciphertext sink ready
//   absorb_pt_o      ciphertext handshake; commit the CT block into the rate
//   tag_valid_o      tag valid
//   tag_ready_i      tag sink ready
//   busy_o           an operation is in progress
//   done_o           one-cycle pulse after the tag handshake
// ----------------------------------------------------------------------------
module ascon_blk_sequencer #(
    parameter int unsigned DATA_AW  = 7,
    parameter int unsigned BLOCK_AW = DATA_AW - 3,
    parameter int unsigned ROUNDS_A = 12,
    parameter int unsigned ROUNDS_B = 6
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                ad_empty_i,
    input  logic [BLOCK_AW-1:0] ad_blk_no_i,
    input  logic [BLOCK_AW:0]   pt_blk_no_i,
    output logic [BLOCK_AW-1:0] ad_blk_cnt_o,
    output logic [BLOCK_AW:0]   pt_blk_cnt_o,
    output logic                perm_start_o,
    output logic [3:0]          perm_rounds_o,
    input  logic                perm_done_i,
    output logic                init_o,
    output logic                key_xor_o,
    output logic                absorb_ad_o,
    output logic                dom_sep_o,
    output logic                ct_valid_o,
    input  logic                ct_ready_i,
    output logic                absorb_pt_o,
    output logic                tag_valid_o,
    input  logic                tag_ready_i,
    output logic                busy_o,
    output logic                done_o
);

    localparam logic [3:0] RND_A = 4'(ROUNDS_A);
    localparam logic [3:0] RND_B = 4'(ROUNDS_B);

    // Every permutation is split into a "command" state that raises
    // perm_start_o and a W_* state that waits for perm_done_i. A done pulse
    // is therefore only ever looked at in a W_* state, which never raises
    // perm_start_o, so stray or early done pulses are ignored by construction.
    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,      // init_o
        S_INIT,      // p^a start
        S_W_INIT,
        S_AD,        // absorb_ad_o
        S_AD_PERM,   // p^b start
        S_W_AD,
        S_DOMSEP,    // dom_sep_o
        S_PT,        // ct_valid_o until handshake
        S_PT_PERM,   // p^b start
        S_W_PT,
        S_FINAL,     // key_xor_o
        S_FIN_PERM,  // p^a start
        S_W_FIN,
        S_TAG        // tag_valid_o until handshake
    } state_e;

    state_e state_q, state_d;

    // Operation parameters captured at start and held for the whole run, so
    // the padding unit may change its inputs mid-operation without effect.
    logic                ad_empty_q;
    logic [BLOCK_AW-1:0] ad_last_q;
    logic [BLOCK_AW:0]   pt_last_q;
    logic                capture;

    logic [BLOCK_AW-1:0] ad_cnt_q, ad_cnt_d;
    logic [BLOCK_AW:0]   pt_cnt_q, pt_cnt_d;
    logic                done_q, done_d;

    logic ad_last_hit;
    logic pt_last_hit;

    // Exact equality on latched values: the counter stops at the last index
    // and can never run past the field width.
    assign ad_last_hit = (ad_cnt_q == ad_last_q);
    assign pt_last_hit = (pt_cnt_q == pt_last_q);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values; blocking here would create order-dependent
    // simulation and mismatch the synthesized netlist.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            ad_cnt_q   <= '0;
            pt_cnt_q   <= '0;
            done_q     <= 1'b0;
            ad_empty_q <= 1'b0;
            ad_last_q  <= '0;
            pt_last_q  <= '0;
        end else begin
            state_q  <= state_d;
            ad_cnt_q <= ad_cnt_d;
            pt_cnt_q <= pt_cnt_d;
            done_q   <= done_d;
            if (capture) begin
                ad_empty_q <= ad_empty_i;
                ad_last_q  <= ad_blk_no_i;
                pt_last_q  <= pt_blk_no_i;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and command decode
    // ------------------------------------------------------------------------
    // NOTE: every signal written here gets a default before the case, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        ad_cnt_d      = ad_cnt_q;
        pt_cnt_d      = pt_cnt_q;
        done_d        = 1'b0;
        capture       = 1'b0;
        init_o        = 1'b0;
        perm_start_o  = 1'b0;
        perm_rounds_o = '0;
        key_xor_o     = 1'b0;
        absorb_ad_o   = 1'b0;
        dom_sep_o     = 1'b0;
        ct_valid_o    = 1'b0;
        absorb_pt_o   = 1'b0;
        tag_valid_o   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    capture  = 1'b1;
                    ad_cnt_d = '0;
                    pt_cnt_d = '0;
                    state_d  = S_LOAD;
                end
            end

            S_LOAD: begin
                init_o  = 1'b1;
                state_d = S_INIT;
            end

            S_INIT: begin
                perm_start_o  = 1'b1;
                perm_rounds_o = RND_A;
                state_d       = S_W_INIT;
            end

            S_W_INIT: begin
                if (perm_done_i) begin
                    key_xor_o = 1'b1;
                    state_d   = ad_empty_q ? S_DOMSEP : S_AD;
                end
            end

            S_AD: begin
                absorb_ad_o = 1'b1;
                state_d     = S_AD_PERM;
            end

            S_AD_PERM: begin
                perm_start_o  = 1'b1;
                perm_rounds_o = RND_B;
                state_d       = S_W_AD;
            end

            S_W_AD: begin
                if (perm_done_i) begin
                    if (ad_last_hit) begin
                        state_d = S_DOMSEP;
                    end else begin
                        ad_cnt_d = ad_cnt_q + 1'b1;
                        state_d  = S_AD;
                    end
                end
            end

            S_DOMSEP: begin
                dom_sep_o = 1'b1;
                state_d   = S_PT;
            end

            S_PT: begin
                // ct_valid_o is a pure state decode, so it cannot drop until
                // the handshake moves the FSM out of S_PT.
                ct_valid_o  = 1'b1;
                absorb_pt_o = ct_ready_i;
                if (ct_ready_i) begin
                    state_d = pt_last_hit ? S_FINAL : S_PT_PERM;
                end
            end

            S_PT_PERM: begin
                perm_start_o  = 1'b1;
                perm_rounds_o = RND_B;
                state_d       = S_W_PT;
            end

            S_W_PT: begin
                if (perm_done_i) begin
                    pt_cnt_d = pt_cnt_q + 1'b1;
                    state_d  = S_PT;
                end
            end

            S_FINAL: begin
                key_xor_o = 1'b1;
                state_d   = S_FIN_PERM;
            end

            S_FIN_PERM: begin
                perm_start_o  = 1'b1;
                perm_rounds_o = RND_A;
                state_d       = S_W_FIN;
            end

            S_W_FIN: begin
                if (perm_done_i) begin
                    key_xor_o = 1'b1;
                    state_d   = S_TAG;
                end
            end

            S_TAG: begin
                tag_valid_o = 1'b1;
                if (tag_ready_i) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ad_blk_cnt_o = ad_cnt_q;
    assign pt_blk_cnt_o = pt_cnt_q;
    assign busy_o       = (state_q != S_IDLE);
    // done_q is only set on the TAG->IDLE transition, so it is high in the
    // first idle cycle, when busy_o has already dropped.
    assign done_o       = done_q;

    // ------------------------------------------------------------------------
    // Protocol properties
    // ------------------------------------------------------------------------
    a_strobes_exclusive: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0({init_o, key_xor_o, absorb_ad_o, dom_sep_o, absorb_pt_o}));

    a_ct_valid_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (ct_valid_o && !ct_ready_i) |=> ct_valid_o);

    a_ad_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ad_cnt_q <= ad_last_q);

    a_pt_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        pt_cnt_q <= pt_last_q);

endmodule

// File: tb/tb_ascon_blk_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ascon_blk_sequencer
//
// Drives ascon_blk_sequencer with a permutation responder, randomized sink
// readiness, stray done pulses and input noise during busy. Every observed
// command/strobe is logged as an event. The log is compared against an event
// list derived from the operation's block counts.
// ----------------------------------------------------------------------------
module tb_ascon_blk_sequencer;

    localparam int BAW = 4;

    // Event codes: type in bits [15:8], payload (rounds or block index) in [7:0]
    localparam int EV_INIT  = 1 << 8;
    localparam int EV_PERM  = 2 << 8;
    localparam int EV_KEYX  = 3 << 8;
    localparam int EV_ABSAD = 4 << 8;
    localparam int EV_DOM   = 5 << 8;
    localparam int EV_CT    = 6 << 8;
    localparam int EV_TAG   = 7 << 8;
    localparam int EV_DONE  = 8 << 8;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic           start_i;
    logic           ad_empty_i;
    logic [BAW-1:0] ad_blk_no_i;
    logic [BAW:0]   pt_blk_no_i;
    logic [BAW-1:0] ad_blk_cnt_o;
    logic [BAW:0]   pt_blk_cnt_o;
    logic           perm_start_o;
    logic [3:0]     perm_rounds_o;
    logic           perm_done_i;
    logic           init_o;
    logic           key_xor_o;
    logic           absorb_ad_o;
    logic           dom_sep_o;
    logic           ct_valid_o;
    logic           ct_ready_i;
    logic           absorb_pt_o;
    logic           tag_valid_o;
    logic           tag_ready_i;
    logic           busy_o;
    logic           done_o;

    ascon_blk_sequencer dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .ad_empty_i    (ad_empty_i),
        .ad_blk_no_i   (ad_blk_no_i),
        .pt_blk_no_i   (pt_blk_no_i),
        .ad_blk_cnt_o  (ad_blk_cnt_o),
        .pt_blk_cnt_o  (pt_blk_cnt_o),
        .perm_start_o  (perm_start_o),
        .perm_rounds_o (perm_rounds_o),
        .perm_done_i   (perm_done_i),
        .init_o        (init_o),
        .key_xor_o     (key_xor_o),
        .absorb_ad_o   (absorb_ad_o),
        .dom_sep_o     (dom_sep_o),
        .ct_valid_o    (ct_valid_o),
        .ct_ready_i    (ct_ready_i),
        .absorb_pt_o   (absorb_pt_o),
        .tag_valid_o   (tag_valid_o),
        .tag_ready_i   (tag_ready_i),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clk_i = ~clk_i;

    // ------------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Environment controls
    int       pend        = 0;    // cycles until the responder's done pulse
    int       maxd        = 1;    // max permutation latency
    int       ready_pct   = 100;  // sink readiness probability
    bit       spurious_en = 1'b0;
    bit       noise_en    = 1'b0;
    bit       req_start   = 1'b0;
    bit       req_ad_empty;
    logic [BAW-1:0] req_ad_no;
    logic [BAW:0]   req_pt_no;
    int       stall_left  = 0;
    bit       stall_active = 1'b0;
    bit       stalled_now  = 1'b0;

    // Monitor state
    int  got_q[$];
    int  ad_t[$];
    int  ct_t[$];
    int  cyc  = 0;
    int  viol = 0;
    bit  prev_ct_wait = 1'b0;

    // ------------------------------------------------------------------------
    // One cycle of stimulus, applied just after the rising edge. Only
    // state-decoded outputs are consulted here.
    // ------------------------------------------------------------------------
    task automatic drive_cycle();
        @(posedge clk_i);
        #1;
        stalled_now = 1'b0;
        perm_done_i = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) perm_done_i = 1'b1;
        end
        if (perm_start_o) begin
            pend = $urandom_range(maxd, 1);
            // stray done in the start cycle itself
            if (spurious_en && $urandom_range(1, 0) == 1) perm_done_i = 1'b1;
        end else if (spurious_en && pend == 0 && !perm_done_i &&
                     (ct_valid_o || tag_valid_o || !busy_o) &&
                     $urandom_range(3, 0) == 0) begin
            perm_done_i = 1'b1;
        end

        if (stall_left > 0 && (stall_active || (ct_valid_o && pt_blk_cnt_o == 1))) begin
            stall_active = 1'b1;
            stall_left--;
            ct_ready_i   = 1'b0;
            stalled_now  = 1'b1;
        end else begin
            stall_active = 1'b0;
            ct_ready_i   = ($urandom_range(99, 0) < ready_pct);
        end
        tag_ready_i = ($urandom_range(99, 0) < ready_pct);

        if (req_start) begin
            start_i     = 1'b1;
            ad_empty_i  = req_ad_empty;
            ad_blk_no_i = req_ad_no;
            pt_blk_no_i = req_pt_no;
            req_start   = 1'b0;
        end else if (busy_o && noise_en) begin
            start_i     = ($urandom_range(3, 0) == 0);
            ad_empty_i  = 1'($urandom);
            ad_blk_no_i = BAW'($urandom);
            pt_blk_no_i = (BAW+1)'($urandom);
        end else begin
            start_i = 1'b0;
        end
    endtask

    // ------------------------------------------------------------------------
    // Sample outputs on the falling edge and log events / protocol breaches.
    // ------------------------------------------------------------------------
    task automatic monitor_cycle();
        int pulses;
        @(negedge clk_i);
        cyc++;
        pulses = int'(init_o) + int'(key_xor_o) + int'(absorb_ad_o) +
                 int'(dom_sep_o) + int'(absorb_pt_o);
        if (pulses > 1) viol++;
        if (absorb_pt_o !== (ct_valid_o & ct_ready_i)) viol++;
        if (prev_ct_wait && !ct_valid_o) viol++;
        prev_ct_wait = ct_valid_o && !ct_ready_i;
        if (done_o && busy_o) viol++;

        if (init_o)       got_q.push_back(EV_INIT);
        if (perm_start_o) got_q.push_back(EV_PERM | int'(perm_rounds_o));
        if (key_xor_o)    got_q.push_back(EV_KEYX);
        if (absorb_ad_o) begin
            got_q.push_back(EV_ABSAD | int'(ad_blk_cnt_o));
            ad_t.push_back(cyc);
        end
        if (dom_sep_o)    got_q.push_back(EV_DOM);
        if (absorb_pt_o) begin
            got_q.push_back(EV_CT | int'(pt_blk_cnt_o));
            ct_t.push_back(cyc);
        end
        if (tag_valid_o && tag_ready_i) got_q.push_back(EV_TAG);
        if (done_o)       got_q.push_back(EV_DONE);

        if (stalled_now) begin
            check("stall_ct_valid", ct_valid_o, 1);
            check("stall_pt_cnt", pt_blk_cnt_o, 1);
            check("stall_absorb_pt", absorb_pt_o, 0);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference: the command sequence of one encryption, from block counts.
    // ------------------------------------------------------------------------
    function automatic void build_expected(input bit ad_empty, input int ad_no,
                                           input int pt_no, output int exp_q[$]);
        exp_q.delete();
        exp_q.push_back(EV_INIT);
        exp_q.push_back(EV_PERM | 12);
        exp_q.push_back(EV_KEYX);
        if (!ad_empty) begin
            for (int i = 0; i <= ad_no; i++) begin
                exp_q.push_back(EV_ABSAD | i);
                exp_q.push_back(EV_PERM | 6);
            end
        end
        exp_q.push_back(EV_DOM);
        for (int i = 0; i <= pt_no; i++) begin
            exp_q.push_back(EV_CT | i);
            if (i < pt_no) exp_q.push_back(EV_PERM | 6);
        end
        exp_q.push_back(EV_KEYX);
        exp_q.push_back(EV_PERM | 12);
        exp_q.push_back(EV_KEYX);
        exp_q.push_back(EV_TAG);
        exp_q.push_back(EV_DONE);
    endfunction

    task automatic run_op(input bit ad_empty, input int ad_no, input int pt_no,
                          input bit check_lat);
        int exp_q[$];
        bit fin = 1'b0;
        build_expected(ad_empty, ad_no, pt_no, exp_q);
        got_q.delete();
        ad_t.delete();
        ct_t.delete();
        viol         = 0;
        req_start    = 1'b1;
        req_ad_empty = ad_empty;
        req_ad_no    = BAW'(ad_no);
        req_pt_no    = (BAW+1)'(pt_no);
        for (int c = 0; c < 4000 && !fin; c++) begin
            drive_cycle();
            monitor_cycle();
            if (done_o) fin = 1'b1;
        end
        check("op_finished", fin, 1);
        check("event_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check("event", (i < got_q.size()) ? got_q[i] : -1, exp_q[i]);
        end
        check("protocol_breaches", viol, 0);
        if (check_lat) begin
            for (int i = 1; i < ad_t.size(); i++) check("ad_block_cycles", ad_t[i] - ad_t[i-1], 3);
            for (int i = 1; i < ct_t.size(); i++) check("pt_block_cycles", ct_t[i] - ct_t[i-1], 3);
        end
    endtask

    task automatic reset_mid_w_pt();
        bit found = 1'b0;
        logic [22:0] all_out;
        got_q.delete();
        ct_t.delete();
        maxd         = 3;
        req_start    = 1'b1;
        req_ad_empty = 1'b1;
        req_ad_no    = '0;
        req_pt_no    = 5'd3;
        for (int c = 0; c < 500 && !found; c++) begin
            drive_cycle();
            monitor_cycle();
            if (perm_start_o && ct_t.size() > 0) found = 1'b1;
        end
        check("reached_w_pt", found, 1);
        @(posedge clk_i);
        #1;
        perm_done_i = 1'b0;
        start_i     = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        all_out = {init_o, key_xor_o, absorb_ad_o, dom_sep_o, ct_valid_o, absorb_pt_o,
                   tag_valid_o, busy_o, done_o, perm_start_o, perm_rounds_o,
                   ad_blk_cnt_o, pt_blk_cnt_o};
        check("async_reset_outputs", all_out, 0);
        pend         = 0;
        prev_ct_wait = 1'b0;
        repeat (2) begin
            @(negedge clk_i);
            check("no_done_in_reset", done_o, 0);
        end
        rst_ni = 1'b1;
        maxd   = 1;
    endtask

    // ------------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------------
    initial begin
        logic [22:0] rst_out;
        rst_ni      = 1'b0;
        start_i     = 1'b0;
        ad_empty_i  = 1'b0;
        ad_blk_no_i = '0;
        pt_blk_no_i = '0;
        perm_done_i = 1'b0;
        ct_ready_i  = 1'b0;
        tag_ready_i = 1'b0;
        #12;
        rst_out = {init_o, key_xor_o, absorb_ad_o, dom_sep_o, ct_valid_o, absorb_pt_o,
                   tag_valid_o, busy_o, done_o, perm_start_o, perm_rounds_o,
                   ad_blk_cnt_o, pt_blk_cnt_o};
        check("reset_state", rst_out, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Minimal op, zero-wait environment
        run_op(1'b1, 0, 0, 1'b1);
        // AD 0..2, PT 0..3, latency checked
        run_op(1'b0, 2, 3, 1'b1);
        // CT sink stalls 5 cycles on PT block 1
        stall_left = 5;
        run_op(1'b1, 0, 2, 1'b0);
        check("stall_consumed", stall_left, 0);
        // start pulses and changing block numbers mid-op, stray done pulses
        noise_en    = 1'b1;
        spurious_en = 1'b1;
        run_op(1'b0, 2, 3, 1'b0);
        noise_en    = 1'b0;
        spurious_en = 1'b0;
        // reset abort in W_PT, then a clean op from counter 0
        reset_mid_w_pt();
        run_op(1'b0, 1, 2, 1'b1);
        // maximum block indices
        run_op(1'b0, 15, 31, 1'b1);

        // randomized operations with waits, backpressure and noise
        noise_en    = 1'b1;
        spurious_en = 1'b1;
        maxd        = 4;
        ready_pct   = 60;
        for (int k = 0; k < 25; k++) begin
            run_op(1'($urandom), $urandom_range(15, 0), $urandom_range(31, 0), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
